// File: rtl/axil_gpio_mc.sv
// axil_gpio_mc: multi-channel AXI4-Lite GPIO slave.
// N_CH channels of GPIO_WIDTH bits, each with DATA_OUT, DIR and synchronised DATA_IN.
// Define GPIO_IRQ_EN to build the per-channel rising-edge interrupt logic (IER/ISR/irq).
module axil_gpio_mc #(
    parameter int N_CH               = 2,
    parameter int GPIO_WIDTH         = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [N_CH*GPIO_WIDTH-1:0]      gpio_i,
    output logic [N_CH*GPIO_WIDTH-1:0]      gpio_o,
    output logic [N_CH*GPIO_WIDTH-1:0]      gpio_t,
    output logic                            irq
);

    localparam int GW = GPIO_WIDTH;
    localparam int PW = N_CH * GPIO_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;
    typedef enum logic [2:0] {
        REG_DOUT, REG_DIR, REG_DIN, REG_RSVD, REG_IER, REG_ISR, REG_BAD
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t  kind;
        logic [1:0] ch;
    } reg_sel_t;

    // Map a byte address onto a register kind and channel index.
    function automatic reg_sel_t decode(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
        reg_sel_t sel;
        sel.kind = REG_BAD;
        sel.ch   = addr[5:4];
        if (!addr[6]) begin
            if (int'(addr[5:4]) < N_CH) begin
                case (addr[3:2])
                    2'd0:    sel.kind = REG_DOUT;
                    2'd1:    sel.kind = REG_DIR;
                    2'd2:    sel.kind = REG_DIN;
                    default: sel.kind = REG_RSVD;
                endcase
            end
        end else if (addr[5:3] == 3'b000) begin
            sel.kind = addr[2] ? REG_ISR : REG_IER;
        end
        return sel;
    endfunction

    // Per-bit write enable derived from the byte strobes.
    function automatic logic [GW-1:0] byte_mask(input logic [C_S_AXI_DATA_WIDTH/8-1:0] strb);
        logic [GW-1:0] m;
        for (int i = 0; i < GW; i++) m[i] = strb[i/8];
        return m;
    endfunction

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    reg_sel_t wr_sel, rd_sel;
    logic     wr_fire, rd_fire;
    logic [GW-1:0] wr_mask;

    logic [PW-1:0] data_out, dir, s1, s2;
    logic [N_CH-1:0] ier, isr;

    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
    logic                          rd_err;

    // Address bits below word granularity, protection and unused data lanes are don't-care.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_wdata, s_axi_wstrb};

    assign wr_sel  = decode(s_axi_awaddr);
    assign rd_sel  = decode(s_axi_araddr);
    assign wr_fire = (w_state == W_ACK);
    assign rd_fire = (r_state == R_ACK);
    assign wr_mask = byte_mask(s_axi_wstrb);

    // Write and read FSM state registers.
    // NOTE: state flops use non-blocking assignments and the async reset in the sensitivity list.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Next-state and handshake outputs for both channels.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        w_next        = w_state;
        r_next        = r_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (w_state)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_next = W_ACK;
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                w_next        = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
        case (r_state)
            R_IDLE: if (s_axi_arvalid) r_next = R_ACK;
            R_ACK: begin
                s_axi_arready = 1'b1;
                r_next        = R_RESP;
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Channel DATA_OUT / DIR registers, updated on the write handshake cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            data_out <= '0;
            dir      <= '0;
        end else if (wr_fire) begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(wr_sel.ch) == c) begin
                    if (wr_sel.kind == REG_DOUT)
                        data_out[c*GW +: GW] <= (data_out[c*GW +: GW] & ~wr_mask) |
                                                (s_axi_wdata[GW-1:0] & wr_mask);
                    if (wr_sel.kind == REG_DIR)
                        dir[c*GW +: GW] <= (dir[c*GW +: GW] & ~wr_mask) |
                                           (s_axi_wdata[GW-1:0] & wr_mask);
                end
            end
        end
    end

    // Write response: captured with the register update, held until bready.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)     s_axi_bresp <= RESP_OKAY;
        else if (wr_fire) s_axi_bresp <= (wr_sel.kind == REG_BAD) ? RESP_SLVERR : RESP_OKAY;
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gpio_i;
            s2 <= s1;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [PW-1:0]   s3, rise;
    logic [N_CH-1:0] isr_set, isr_clr;

    // Rising edges on input-direction bits, reduced per channel; W1C mask from lane 0.
    always_comb begin
        rise = s2 & ~s3 & ~dir;
        for (int c = 0; c < N_CH; c++) isr_set[c] = |rise[c*GW +: GW];
        isr_clr = '0;
        if (wr_fire && wr_sel.kind == REG_ISR && s_axi_wstrb[0])
            isr_clr = s_axi_wdata[N_CH-1:0];
    end

    // Edge history, enable and status registers; a set in the clearing cycle wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s3  <= '0;
            ier <= '0;
            isr <= '0;
        end else begin
            s3  <= s2;
            isr <= (isr & ~isr_clr) | isr_set;
            if (wr_fire && wr_sel.kind == REG_IER && s_axi_wstrb[0])
                ier <= s_axi_wdata[N_CH-1:0];
        end
    end

    assign irq = |(isr & ier);
`else
    assign ier = '0;
    assign isr = '0;
    assign irq = 1'b0;
`endif

    assign gpio_o = data_out;
    assign gpio_t = ~dir;

    // Read data mux; unmapped addresses return zero with an error flag.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (rd_sel.kind)
            REG_DOUT: rd_word[GW-1:0]   = data_out[int'(rd_sel.ch)*GW +: GW];
            REG_DIR:  rd_word[GW-1:0]   = dir[int'(rd_sel.ch)*GW +: GW];
            REG_DIN:  rd_word[GW-1:0]   = s2[int'(rd_sel.ch)*GW +: GW];
            REG_IER:  rd_word[N_CH-1:0] = ier;
            REG_ISR:  rd_word[N_CH-1:0] = isr;
            REG_RSVD: rd_word           = '0;
            default:  rd_err            = 1'b1;
        endcase
    end

    // Read response: captured on the arready cycle, held until rready.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (rd_fire) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axil_gpio_mc.sv
// Self-checking bench for axil_gpio_mc (N_CH=2, GPIO_WIDTH=8).
// Interrupt checks follow the GPIO_IRQ_EN build option of the design.
module tb_axil_gpio_mc;

    localparam int N_CH = 2;
    localparam int GW   = 8;
    localparam int PW   = N_CH * GW;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [6:0]    s_axi_awaddr = '0;
    logic [2:0]    s_axi_awprot = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [6:0]    s_axi_araddr = '0;
    logic [2:0]    s_axi_arprot = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic [PW-1:0] gpio_i = '0;
    logic [PW-1:0] gpio_o;
    logic [PW-1:0] gpio_t;
    logic          irq;

    always #5 ACLK = ~ACLK;

    axil_gpio_mc #(.N_CH(N_CH), .GPIO_WIDTH(GW), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic [1:0] exp_b[$];
    rd_exp_t    exp_r[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // Issue address+data together, check handshake timing, then complete B via the scoreboard.
    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        int n;
        exp_b.push_back(resp);
        @(negedge ACLK);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!s_axi_awready && n < 16);
        check("aw_w_ready", {30'b0, s_axi_awready, s_axi_wready}, 32'h3);
        check("aw_latency", n, 1);
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("aw_pulse", s_axi_awready, 0);
        n = 0;
        while (!s_axi_bvalid && n < 16) begin @(negedge ACLK); n++; end
        check("b_valid", s_axi_bvalid, 1);
        if (s_axi_bvalid) begin
            check("bresp", s_axi_bresp, exp_b.pop_front());
            s_axi_bready = 1'b1;
            @(negedge ACLK);
            s_axi_bready = 1'b0;
        end else begin
            void'(exp_b.pop_front());
        end
    endtask

    task automatic axi_read(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n;
        rd_exp_t e, got;
        e.data = data; e.resp = resp;
        exp_r.push_back(e);
        @(negedge ACLK);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!s_axi_arready && n < 16);
        check("ar_latency", n, 1);
        @(negedge ACLK);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 16) begin @(negedge ACLK); n++; end
        check("r_valid", s_axi_rvalid, 1);
        got = exp_r.pop_front();
        if (s_axi_rvalid) begin
            check($sformatf("rdata@%02h", addr), s_axi_rdata, got.data);
            check($sformatf("rresp@%02h", addr), s_axi_rresp, got.resp);
            s_axi_rready = 1'b1;
            @(negedge ACLK);
            s_axi_rready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        #100;
        check("rst_gpio_t", gpio_t, 16'hFFFF);
        check("rst_gpio_o", gpio_o, 16'h0000);
        check("rst_irq", irq, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        #100;
        ARESETN = 1'b1;
        axi_read(7'h04, 32'h0, OKAY);

        // Channel 1 output data and direction
        axi_write(7'h10, 32'h0000_00A5, 4'hF, OKAY);
        axi_write(7'h14, 32'h0000_00FF, 4'hF, OKAY);
        check("gpio_o_ch1", gpio_o[15:8], 8'hA5);
        check("gpio_t", gpio_t, 16'h00FF);
        axi_read(7'h10, 32'h0000_00A5, OKAY);

        // Byte strobes on channel 0; bits above GPIO_WIDTH read 0
        axi_write(7'h00, 32'h1234_5678, 4'b0001, OKAY);
        axi_read(7'h00, 32'h0000_0078, OKAY);
        axi_write(7'h00, 32'hFFFF_FFFF, 4'b0100, OKAY);
        axi_read(7'h00, 32'h0000_0078, OKAY);
        axi_write(7'h00, 32'h0000_AB00, 4'b0010, OKAY);
        check("gpio_o_ch0", gpio_o[7:0], 8'h78);

        // Synchronised inputs, RO DATA_IN, reserved slot
        gpio_i = 16'h3C5A;
        wait_cycles(4);
        axi_read(7'h08, 32'h0000_005A, OKAY);
        axi_read(7'h18, 32'h0000_003C, OKAY);
        axi_write(7'h08, 32'h0000_0000, 4'hF, OKAY);
        axi_read(7'h08, 32'h0000_005A, OKAY);
        axi_read(7'h0C, 32'h0, OKAY);

        // Error decodes
        axi_read(7'h20, 32'h0, SLVERR);
        axi_read(7'h50, 32'h0, SLVERR);
        axi_write(7'h24, 32'hFFFF_FFFF, 4'hF, SLVERR);
        axi_read(7'h04, 32'h0, OKAY);
        axi_read(7'h14, 32'h0000_00FF, OKAY);

`ifdef GPIO_IRQ_EN
        // Edges from the 0x5A input pattern latched ISR[0]; IER=0 masks irq
        axi_read(7'h44, 32'h1, OKAY);
        check("irq_masked", irq, 0);
        axi_write(7'h44, 32'h1, 4'hF, OKAY);
        axi_read(7'h44, 32'h0, OKAY);
        axi_write(7'h40, 32'h1, 4'hF, OKAY);
        axi_read(7'h40, 32'h1, OKAY);

        // Falling edge: no interrupt
        @(negedge ACLK); gpio_i[3] = 1'b0;
        wait_cycles(4);
        check("irq_fall", irq, 0);

        // Rising edge on input bit 3
        gpio_i[3] = 1'b1;
        n = 0;
        while (!irq && n < 8) begin @(negedge ACLK); n++; end
        check("irq_rise", irq, 1);
        check("irq_latency_le3", (n <= 3), 1);
        axi_read(7'h44, 32'h1, OKAY);

        // W1C with lane 0 disabled clears nothing
        axi_write(7'h44, 32'h1, 4'b1110, OKAY);
        check("irq_strb0", irq, 1);
        axi_write(7'h44, 32'h1, 4'hF, OKAY);
        check("irq_cleared", irq, 0);

        // Output-direction channel never interrupts
        axi_write(7'h40, 32'h3, 4'hF, OKAY);
        @(negedge ACLK); gpio_i[15:8] = 8'h00;
        wait_cycles(4);
        gpio_i[15:8] = 8'hFF;
        wait_cycles(4);
        axi_read(7'h44, 32'h0, OKAY);
        check("irq_out_dir", irq, 0);

        // New edge coinciding with the clear: set wins
        @(negedge ACLK); gpio_i[3] = 1'b0;
        wait_cycles(4);
        gpio_i[3] = 1'b1;
        axi_write(7'h44, 32'h1, 4'hF, OKAY);
        axi_read(7'h44, 32'h1, OKAY);
        check("irq_set_wins", irq, 1);
        axi_write(7'h44, 32'h1, 4'hF, OKAY);
        axi_read(7'h44, 32'h0, OKAY);
`else
        // Interrupt registers absent: read 0 with OKAY, writes ignored, irq tied low
        axi_write(7'h40, 32'h3, 4'hF, OKAY);
        axi_read(7'h40, 32'h0, OKAY);
        axi_write(7'h44, 32'h3, 4'hF, OKAY);
        axi_read(7'h44, 32'h0, OKAY);
        @(negedge ACLK); gpio_i[3] = 1'b0;
        wait_cycles(4);
        gpio_i[3] = 1'b1;
        wait_cycles(5);
        check("irq_tied", irq, 0);
`endif

        // Reset while a write response is pending
        @(negedge ACLK);
        s_axi_awaddr = 7'h00; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!s_axi_awready && n < 16);
        check("mid_awready", s_axi_awready, 1);
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        wait_cycles(2);
        check("mid_bvalid_held", s_axi_bvalid, 1);
        check("mid_gpio_o", gpio_o[7:0], 8'h55);
        #2 ARESETN = 1'b0;
        #1;
        check("mid_bvalid_drop", s_axi_bvalid, 0);
        check("mid_gpio_o_rst", gpio_o, 16'h0000);
        check("mid_gpio_t_rst", gpio_t, 16'hFFFF);
        @(negedge ACLK);
        ARESETN = 1'b1;
        axi_read(7'h00, 32'h0, OKAY);
        axi_write(7'h00, 32'h66, 4'hF, OKAY);
        axi_read(7'h00, 32'h66, OKAY);
        check("post_rst_gpio_o", gpio_o[7:0], 8'h66);

        check("scoreboard_empty", exp_b.size() + exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
